// File: rtl/mem_access_stage_pkg.sv
// Shared types and constants for the MEM pipeline stage.
package mem_access_stage_pkg;

  localparam int DEFAULT_DATA_W = 32;

  // Bit positions inside the WB and M control fields.
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_READ      = 1;
  localparam int M_WRITE     = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory bus: req/gnt address phase followed by an rvalid data pulse for reads.
interface mem_access_stage_if #(
  parameter int DATA_W = 32
) ();
  logic              mem_req;
  logic              mem_we;
  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/mem_access_stage_mem_wb.sv
// MEM/WB pipeline register: full load, or bubble (clear WB control, keep the rest).
module mem_wb_reg #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              load_i,
  input  logic              bubble_i,
  input  logic [1:0]        wb_i,
  input  logic [DATA_W-1:0] rdata_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [4:0]        rd_i,
  output logic [1:0]        wb_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [4:0]        rd_o
);
  logic [1:0]        wb_d, wb_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic [DATA_W-1:0] alu_d, alu_q;
  logic [4:0]        rd_d, rd_q;

  // Select between load, bubble and hold for the next register contents.
  always_comb begin
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    if (load_i) begin
      wb_d    = wb_i;
      rdata_d = rdata_i;
      alu_d   = alu_i;
      rd_d    = rd_i;
    end else if (bubble_i) begin
      wb_d = 2'b00;
    end else begin
      wb_d = wb_q;
    end
  end

  // Pipeline register storage with asynchronous clear.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wb_q    <= 2'b00;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= 5'd0;
    end else begin
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  assign wb_o    = wb_q;
  assign rdata_o = rdata_q;
  assign alu_o   = alu_q;
  assign rd_o    = rd_q;
endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: runs one data-memory transaction per memory instruction, stalling
// upstream until it completes (or times out), then loads MEM/WB.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int DATA_W  = DEFAULT_DATA_W,
  parameter int TIMEOUT = 64,
  parameter int TO_W    = 7
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [1:0]          WB_i,
  input  logic [1:0]          M_i,
  input  logic [DATA_W-1:0]   ALUresult_i,
  input  logic [DATA_W-1:0]   WriteData_i,
  input  logic [4:0]          RegDst_i,
  mem_access_stage_if.master  bus,
  output logic                stall_o,
  output logic                err_o,
  output logic [1:0]          WB_o,
  output logic [DATA_W-1:0]   ReadData_o,
  output logic [DATA_W-1:0]   ALUresult_o,
  output logic [4:0]          RegDst_o
);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_e            state_d, state_q;
  logic [TO_W-1:0]   cnt_d, cnt_q;
  logic              req_d, req_q;
  logic              we_d, we_q;
  logic              err_d, err_q;
  logic [DATA_W-1:0] addr_d, addr_q;
  logic [DATA_W-1:0] wdata_d, wdata_q;
  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic [1:0]        wb_d, wb_q;
  logic [4:0]        rd_d, rd_q;

  logic              busy;
  logic              timeout_hit;
  logic              mw_load, mw_bubble;
  logic [1:0]        mw_wb;
  logic [DATA_W-1:0] mw_rdata, mw_alu;
  logic [4:0]        mw_rd;

  assign timeout_hit = (cnt_q >= TO_LAST);

  // Next-state, holding-register and MEM/WB control decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    wb_d      = wb_q;
    rd_d      = rd_q;
    busy      = 1'b0;
    mw_load   = 1'b0;
    mw_bubble = 1'b0;
    mw_wb     = WB_i;
    mw_rdata  = '0;
    mw_alu    = ALUresult_i;
    mw_rd     = RegDst_i;
    case (state_q)
      ST_IDLE: begin
        if (M_i != 2'b00) begin
          busy      = 1'b1;
          mw_bubble = 1'b1;
          state_d   = ST_REQ;
          req_d     = 1'b1;
          cnt_d     = '0;
          // An illegal read+write request is flagged and executed as a write.
          we_d      = M_i[M_WRITE];
          addr_d    = ALUresult_i;
          wdata_d   = WriteData_i;
          rdata_d   = '0;
          wb_d      = WB_i;
          rd_d      = RegDst_i;
          err_d     = err_q | (M_i == 2'b11);
        end else begin
          mw_load = 1'b1;
        end
      end
      ST_REQ: begin
        busy      = 1'b1;
        mw_bubble = 1'b1;
        cnt_d     = cnt_q + TO_W'(1);
        // rvalid is ignored here: data cannot precede the address grant.
        if (bus.mem_gnt) begin
          req_d   = 1'b0;
          state_d = we_q ? ST_DONE : ST_RESP;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          state_d = ST_DONE;
          rdata_d = '0;
          err_d   = 1'b1;
        end else begin
          state_d = ST_REQ;
        end
      end
      ST_RESP: begin
        busy      = 1'b1;
        mw_bubble = 1'b1;
        cnt_d     = cnt_q + TO_W'(1);
        if (bus.mem_rvalid) begin
          rdata_d = bus.mem_rdata;
          state_d = ST_DONE;
        end else if (timeout_hit) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          state_d = ST_RESP;
        end
      end
      ST_DONE: begin
        // Whatever M_i shows now is the same frozen instruction; it is not reissued.
        mw_load  = 1'b1;
        mw_wb    = wb_q;
        mw_rdata = rdata_q;
        mw_alu   = addr_q;
        mw_rd    = rd_q;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  // FSM state, timeout counter and bus-facing holding registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wb_q    <= 2'b00;
      rd_q    <= 5'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      we_q    <= we_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wb_q    <= wb_d;
      rd_q    <= rd_d;
    end
  end

  mem_wb_reg #(.DATA_W(DATA_W)) u_mem_wb (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .load_i   (mw_load),
    .bubble_i (mw_bubble),
    .wb_i     (mw_wb),
    .rdata_i  (mw_rdata),
    .alu_i    (mw_alu),
    .rd_i     (mw_rd),
    .wb_o     (WB_o),
    .rdata_o  (ReadData_o),
    .alu_o    (ALUresult_o),
    .rd_o     (RegDst_o)
  );

  // Stall is suppressed in reset so every output reads 0 while rst_n_i is low.
  assign stall_o       = rst_n_i & busy;
  assign err_o         = err_q;
  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed self-checking bench for mem_access_stage (TIMEOUT = 8).
module tb_mem_access_stage;
  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic [1:0]  WB_i, M_i;
  logic [31:0] ALUresult_i, WriteData_i;
  logic [4:0]  RegDst_i;
  logic        stall_o, err_o;
  logic [1:0]  WB_o;
  logic [31:0] ReadData_o, ALUresult_o;
  logic [4:0]  RegDst_o;

  int n_cmp = 0;
  int n_mis = 0;

  mem_access_stage_if #(.DATA_W(32)) bus ();

  mem_access_stage #(.DATA_W(32), .TIMEOUT(8), .TO_W(7)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .WB_i        (WB_i),
    .M_i         (M_i),
    .ALUresult_i (ALUresult_i),
    .WriteData_i (WriteData_i),
    .RegDst_i    (RegDst_i),
    .bus         (bus),
    .stall_o     (stall_o),
    .err_o       (err_o),
    .WB_o        (WB_o),
    .ReadData_o  (ReadData_o),
    .ALUresult_o (ALUresult_o),
    .RegDst_o    (RegDst_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [1:0] wb, input logic [1:0] m, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] rd);
    WB_i = wb; M_i = m; ALUresult_i = alu; WriteData_i = wd; RegDst_i = rd;
  endtask

  task automatic nop();
    drive(2'b00, 2'b00, 32'h0, 32'h0, 5'd0);
  endtask

  // Back-to-back instruction stream and bookkeeping
  logic [1:0]  s_wb [2];
  logic [1:0]  s_m  [2];
  logic [31:0] s_a  [2];
  logic [31:0] s_d  [2];
  logic [4:0]  s_rd [2];

  initial begin
    int n;
    int idx;
    int pulses;
    int wr_gnts;
    int rd_gnts;
    int c_done;
    logic stl;
    logic pend;
    logic gwe;

    rst_n_i = 1'b0;
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    // Reset with random inputs, including an illegal M code.
    for (int i = 0; i < 3; i++) begin
      drive(2'($urandom), 2'b11, $urandom, $urandom, 5'($urandom));
      bus.mem_gnt = 1'($urandom); bus.mem_rvalid = 1'($urandom); bus.mem_rdata = $urandom;
      step();
    end
    chk("rst_req",   {63'd0, bus.mem_req}, 64'd0);
    chk("rst_stall", {63'd0, stall_o}, 64'd0);
    chk("rst_err",   {63'd0, err_o}, 64'd0);
    chk("rst_wb",    {62'd0, WB_o}, 64'd0);
    chk("rst_outs",  {ReadData_o | ALUresult_o | bus.mem_addr | bus.mem_wdata, 27'd0, RegDst_o}, 64'd0);
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    nop();
    step();
    rst_n_i = 1'b1;
    step();

    // Plain ALU op: one-cycle pass-through, no stall.
    drive(2'b10, 2'b00, 32'h5, 32'h0, 5'd3);
    #1 chk("alu_stall", {63'd0, stall_o}, 64'd0);
    step();
    chk("alu_wb",  {62'd0, WB_o}, 64'd2);
    chk("alu_res", {32'd0, ALUresult_o}, 64'h5);
    chk("alu_rd",  {59'd0, RegDst_o}, 64'd3);
    chk("alu_rdata", {32'd0, ReadData_o}, 64'd0);

    // Load: gnt in first REQ cycle, rvalid two cycles later.
    drive(2'b11, 2'b10, 32'h100, 32'h0, 5'd8);
    #1 chk("ld_stall_idle", {63'd0, stall_o}, 64'd1);
    step();
    chk("ld_req",  {63'd0, bus.mem_req}, 64'd1);
    chk("ld_we",   {63'd0, bus.mem_we}, 64'd0);
    chk("ld_addr", {32'd0, bus.mem_addr}, 64'h100);
    chk("ld_bubble_req", {62'd0, WB_o}, 64'd0);
    bus.mem_gnt = 1'b1;
    #1 chk("ld_stall_req", {63'd0, stall_o}, 64'd1);
    step();
    bus.mem_gnt = 1'b0;
    chk("ld_req_drop", {63'd0, bus.mem_req}, 64'd0);
    chk("ld_stall_resp1", {63'd0, stall_o}, 64'd1);
    chk("ld_bubble_resp1", {62'd0, WB_o}, 64'd0);
    step();
    bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'hDEADBEEF;
    #1 chk("ld_stall_resp2", {63'd0, stall_o}, 64'd1);
    step();
    bus.mem_rvalid = 1'b0; bus.mem_rdata = 32'h0;
    chk("ld_stall_done", {63'd0, stall_o}, 64'd0);
    chk("ld_bubble_done", {62'd0, WB_o}, 64'd0);
    step();
    nop();
    chk("ld_wb",    {62'd0, WB_o}, 64'd3);
    chk("ld_rdata", {32'd0, ReadData_o}, 64'hDEADBEEF);
    chk("ld_rd",    {59'd0, RegDst_o}, 64'd8);
    chk("ld_alu",   {32'd0, ALUresult_o}, 64'h100);
    step();

    // Store: gnt only in the 4th REQ cycle.
    drive(2'b00, 2'b01, 32'h40, 32'h1234, 5'd5);
    #1 chk("st_stall_idle", {63'd0, stall_o}, 64'd1);
    step();
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("st_req%0d", i), {63'd0, bus.mem_req}, 64'd1);
      chk($sformatf("st_we%0d", i), {63'd0, bus.mem_we}, 64'd1);
      chk($sformatf("st_addr%0d", i), {32'd0, bus.mem_addr}, 64'h40);
      chk($sformatf("st_wdata%0d", i), {32'd0, bus.mem_wdata}, 64'h1234);
      if (i == 3) bus.mem_gnt = 1'b1;
      step();
    end
    bus.mem_gnt = 1'b0;
    chk("st_done_req", {63'd0, bus.mem_req}, 64'd0);
    chk("st_done_stall", {63'd0, stall_o}, 64'd0);
    step();
    nop();
    chk("st_rdata", {32'd0, ReadData_o}, 64'd0);
    chk("st_alu",   {32'd0, ALUresult_o}, 64'h40);
    chk("st_rd",    {59'd0, RegDst_o}, 64'd5);
    chk("st_err",   {63'd0, err_o}, 64'd0);
    step();

    // Timeout: read never granted.
    drive(2'b11, 2'b10, 32'h200, 32'h0, 5'd9);
    step();
    n = 0;
    while (bus.mem_req && n < 20) begin
      n++;
      step();
    end
    chk("to_req_cycles", 64'(n), 64'd8);
    chk("to_err", {63'd0, err_o}, 64'd1);
    chk("to_stall_done", {63'd0, stall_o}, 64'd0);
    step();
    nop();
    chk("to_rdata", {32'd0, ReadData_o}, 64'd0);
    chk("to_wb",    {62'd0, WB_o}, 64'd3);
    drive(2'b10, 2'b00, 32'h77, 32'h0, 5'd4);
    #1 chk("to_idle_stall", {63'd0, stall_o}, 64'd0);
    step();
    chk("post_to_alu", {32'd0, ALUresult_o}, 64'h77);
    chk("post_to_wb",  {62'd0, WB_o}, 64'd2);
    chk("err_sticky",  {63'd0, err_o}, 64'd1);

    // Reset dropped in the middle of a REQ phase.
    drive(2'b11, 2'b10, 32'h300, 32'h0, 5'd1);
    step();
    chk("mid_req_up", {63'd0, bus.mem_req}, 64'd1);
    #2 rst_n_i = 1'b0;
    #1 chk("mid_rst_req", {63'd0, bus.mem_req}, 64'd0);
    chk("mid_rst_err", {63'd0, err_o}, 64'd0);
    nop();
    step();
    rst_n_i = 1'b1;
    bus.mem_gnt = 1'b1; bus.mem_rvalid = 1'b1; bus.mem_rdata = 32'h55;
    step();
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("late_rsp_req",   {63'd0, bus.mem_req}, 64'd0);
    chk("late_rsp_stall", {63'd0, stall_o}, 64'd0);
    chk("late_rsp_rdata", {32'd0, ReadData_o}, 64'd0);

    // Illegal M=11: flagged and executed as a write.
    drive(2'b00, 2'b11, 32'h80, 32'hAA, 5'd0);
    step();
    chk("ill_err", {63'd0, err_o}, 64'd1);
    chk("ill_req", {63'd0, bus.mem_req}, 64'd1);
    chk("ill_we",  {63'd0, bus.mem_we}, 64'd1);
    bus.mem_gnt = 1'b1;
    step();
    bus.mem_gnt = 1'b0;
    chk("ill_done_stall", {63'd0, stall_o}, 64'd0);
    step();
    nop();
    step();

    // Back-to-back load then store with a first-opportunity responder.
    s_wb[0] = 2'b11; s_m[0] = 2'b10; s_a[0] = 32'h300; s_d[0] = 32'h0;  s_rd[0] = 5'd10;
    s_wb[1] = 2'b00; s_m[1] = 2'b01; s_a[1] = 32'h304; s_d[1] = 32'h99; s_rd[1] = 5'd11;
    idx = 0; pulses = 0; wr_gnts = 0; rd_gnts = 0; c_done = -1; pend = 1'b0;
    drive(s_wb[0], s_m[0], s_a[0], s_d[0], s_rd[0]);
    for (int c = 1; c <= 14; c++) begin
      bus.mem_gnt = bus.mem_req;
      gwe = bus.mem_we;
      bus.mem_rvalid = pend;
      bus.mem_rdata = pend ? 32'hCAFEF00D : 32'h0;
      if (bus.mem_gnt && gwe) wr_gnts++;
      if (bus.mem_gnt && !gwe) rd_gnts++;
      #1 stl = stall_o;
      step();
      pend = bus.mem_gnt && !gwe;
      if (!stl) begin
        idx++;
        if (idx == 2) c_done = c;
        if (idx < 2) drive(s_wb[idx], s_m[idx], s_a[idx], s_d[idx], s_rd[idx]);
        else nop();
      end
      if (WB_o[1]) begin
        pulses++;
        chk("b2b_pulse_rd", {59'd0, RegDst_o}, 64'd10);
        chk("b2b_pulse_data", {32'd0, ReadData_o}, 64'hCAFEF00D);
      end
    end
    bus.mem_gnt = 1'b0; bus.mem_rvalid = 1'b0;
    chk("b2b_pulses", 64'(pulses), 64'd1);
    chk("b2b_rd_gnts", 64'(rd_gnts), 64'd1);
    chk("b2b_wr_gnts", 64'(wr_gnts), 64'd1);
    chk("b2b_cycles", 64'(c_done), 64'd7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
MEM pipeline stage sitting directly downstream of the EX/MEM register. It consumes WB/M control, ALU result, store data and destination register, and drives a req/gnt/rvalid data-memory bus. It stalls the upstream pipeline while a transaction is outstanding, then loads the MEM/WB pipeline register. A timeout counter aborts hung transactions and flags a sticky error.

Parameters:
DATA_W, 32, width of address, ALU result, store and load data
TIMEOUT, 64, max cycles spent in REQ plus RESP before abort (>=2)
TO_W, 7, timeout counter width; must hold TIMEOUT

Ports:
clk_i  in  1  clock, rising edge
rst_n_i  in  1  reset, asynchronous, active-low; one clock
WB_i  in  2  [1]=RegWrite, [0]=MemtoReg, from EX/MEM
M_i  in  2  [1]=MemRead, [0]=MemWrite, from EX/MEM
ALUresult_i  in  DATA_W  memory address / ALU result
WriteData_i  in  DATA_W  store data
RegDst_i  in  5  destination register
mem_req_o  out  1  bus request, registered
mem_we_o  out  1  1=write, 0=read; valid while mem_req_o=1
mem_addr_o  out  DATA_W  bus address; held while mem_req_o=1
mem_wdata_o  out  DATA_W  store data; held while mem_req_o=1
mem_gnt_i  in  1  address phase accepted, sampled while mem_req_o=1
mem_rvalid_i  in  1  read data valid, 1-cycle pulse
mem_rdata_i  in  DATA_W  read data, sampled with mem_rvalid_i
stall_o  out  1  combinational; freezes PC, IF/ID, ID/EX and EX/MEM
err_o  out  1  sticky error: timeout or illegal M_i=11
WB_o  out  2  MEM/WB control
ReadData_o  out  DATA_W  MEM/WB load data
ALUresult_o  out  DATA_W  MEM/WB ALU result
RegDst_o  out  5  MEM/WB destination register

Behaviour:
- Async reset (rst_n_i=0): state=IDLE, timeout counter=0, holding regs=0, all outputs 0 (including mem_req_o and err_o), independent of the clock.
- Reset asserted mid-transaction abandons it. mem_req_o drops immediately. Late gnt/rvalid after reset release are ignored while in IDLE.
- FSM states: IDLE, REQ, RESP, DONE.
- IDLE, M_i=00: no stall. MEM/WB loads WB_i, ALUresult_i, RegDst_i on the edge. ReadData_o=0. Latency is 1 cycle.
- IDLE, M_i!=00:
  - stall_o=1 in the same cycle.
  - Capture WB_i, ALUresult_i, WriteData_i, RegDst_i and we=M_i[0] into holding regs.
  - M_i=11 sets err_o and is treated as a write.
  - Next state REQ. mem_req_o=1 from the next cycle.
  - MEM/WB loads a bubble: WB_o=00, other fields unchanged.
- REQ: mem_req_o=1 with stable addr/we/wdata. On mem_gnt_i: write goes to DONE, read goes to RESP. mem_req_o drops on the edge after gnt.
- RESP: mem_req_o=0. On mem_rvalid_i, capture mem_rdata_i and go to DONE. rvalid arriving in the same cycle as gnt is not legal bus behaviour and is ignored.
- DONE:
  - stall_o=0.
  - MEM/WB loads the held WB, read data (0 for stores), ALU result and RegDst.
  - Next state IDLE.
  - The M_i still presented during DONE is ignored. Upstream advances on this edge.
- While state is REQ or RESP: stall_o=1 and MEM/WB loads a bubble (WB_o=00) every cycle, so the register file is never written twice.
- Timeout counter:
  - Clears on IDLE->REQ and increments each REQ/RESP cycle.
  - When it reaches TIMEOUT-1 without completion: next state DONE, mem_req_o drops, held read data forced to 0, err_o set.
  - err_o clears only on reset.
- Load-to-use hazards are handled upstream. This block only reports stall_o.
- Read-read back to back: minimum 4 cycles per access (IDLE, REQ, RESP, DONE) with gnt and rvalid each on the first possible cycle.

Decomposition:
- Shared package: FSM state typedef (IDLE/REQ/RESP/DONE); bit-index constants WB_REGWRITE=1, WB_MEMTOREG=0, M_READ=1, M_WRITE=0; default DATA_W.
- One natural sub-module: mem_wb_reg. It holds the MEM/WB register with a load and a bubble input, async active-low reset, outputs reset to 0.

Test Plan:
- Reset: hold rst_n_i=0 with random inputs -> all outputs 0; drop reset mid-REQ -> mem_req_o falls without waiting for a clock edge.
- ALU op, WB_i=10, ALU=0x0000_0005, Rd=3 -> after 1 edge WB_o=10, ALUresult_o=5, RegDst_o=3, stall_o never 1.
- Load, M_i=10, addr=0x100, gnt at the 1st REQ cycle, rvalid 2 cycles later with data 0xDEADBEEF, Rd=8, WB=11:
  - stall_o is high in IDLE, REQ and both RESP cycles.
  - WB_o=00 during the stall.
  - At DONE the edge loads ReadData_o=0xDEADBEEF, RegDst_o=8, WB_o=11.
- Store, M_i=01, addr=0x40, data=0x1234, gnt delayed 3 cycles:
  - mem_we_o=1 and addr/wdata stable for all 4 REQ cycles.
  - DONE occurs 1 cycle after gnt.
  - ReadData_o=0.
- Timeout with TIMEOUT=8: issue a read and never assert gnt -> exactly 8 REQ cycles, err_o=1, ReadData_o=0, FSM returns to IDLE. The next ALU op completes normally.
- Illegal M_i=11 -> err_o=1 and the bus performs a write (mem_we_o=1). Back-to-back load then store completes both in order with no lost or duplicated WB_o=1x pulse.
